// File: rtl/exp_sum_accum_if.sv
// Score-in / normalised-sum-out handshake bundle for exp_sum_accum.
// master drives scores and out_ready; slave is the accumulator.
interface exp_sum_accum_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = DATA_W + $clog2(MAX_LEN)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_mant;
  logic [$clog2(ACC_W)-1:0]   out_shift;
  logic [$clog2(MAX_LEN):0]   out_count;
  logic                       out_zero;
  logic                       out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mant, out_shift, out_count, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mant, out_shift, out_count, out_zero, out_ovf
  );
endinterface

// File: rtl/exp_sum_accum.sv
// Frame accumulator + left normaliser; result k+1 edges after closing element, held until out_ready.
// in_ready low outside ACC. `EXP_SUM_ROUND_EN` selects round-to-nearest mantissa (default truncate).
module exp_sum_accum #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = DATA_W + $clog2(MAX_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  exp_sum_accum_if.slave bus_io
);
  localparam int SH_W  = $clog2(ACC_W);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {S_ACC, S_NORM, S_OUT} state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [SH_W-1:0]   shift_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_mant_q;
  logic [SH_W-1:0]   out_shift_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_zero_q;
  logic              out_ovf_q;

  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  count_d;
  logic              full_d;
  logic [DATA_W-1:0] mant_d;

  assign acc_d   = acc_q + ACC_W'(bus_io.in_data);
  assign count_d = count_q + CNT_W'(1);
  assign full_d  = (count_d == CNT_W'(MAX_LEN));

`ifdef EXP_SUM_ROUND_EN
  // One extra bit catches the 0xFF..+1 carry so it can saturate.
  logic [DATA_W:0] rnd_d;
  assign rnd_d  = {1'b0, acc_q[ACC_W-1 -: DATA_W]} + (DATA_W+1)'(acc_q[ACC_W-DATA_W-1]);
  assign mant_d = rnd_d[DATA_W] ? {DATA_W{1'b1}} : rnd_d[DATA_W-1:0];
`else
  assign mant_d = acc_q[ACC_W-1 -: DATA_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_shift_q <= '0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (bus_io.in_valid) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            if (bus_io.in_last || full_d) begin
              state_q    <= S_NORM;
              in_ready_q <= 1'b0;
              ovf_q      <= full_d && !bus_io.in_last;
            end
          end
        end
        S_NORM: begin
          if (acc_q == '0) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            out_mant_q  <= '0;
            out_shift_q <= '0;
            out_count_q <= count_q;
            out_zero_q  <= 1'b1;
            out_ovf_q   <= ovf_q;
          end else if (acc_q[ACC_W-1]) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            out_mant_q  <= mant_d;
            out_shift_q <= shift_q;
            out_count_q <= count_q;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= ovf_q;
          end else begin
            acc_q   <= acc_q << 1;
            shift_q <= shift_q + SH_W'(1);
          end
        end
        S_OUT: begin
          if (bus_io.out_ready) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_shift_q <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_mant  = out_mant_q;
  assign bus_io.out_shift = out_shift_q;
  assign bus_io.out_count = out_count_q;
  assign bus_io.out_zero  = out_zero_q;
  assign bus_io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_exp_sum_accum.sv
// Table-driven frames with a result scoreboard, plus hold/handshake and reset-abort sequences.
module tb_exp_sum_accum;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = DATA_W + $clog2(MAX_LEN);
`ifdef EXP_SUM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk;
  logic rst;

  exp_sum_accum_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) bus ();

  exp_sum_accum #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [15:0][7:0] d;
    bit               last;
    logic [7:0]       mant;
    logic [3:0]       shift;
    logic [4:0]       cnt;
    bit               zero;
    bit               ovf;
    int               lat;
  } vec_t;

  typedef struct {
    logic [7:0] mant;
    logic [3:0] shift;
    logic [4:0] cnt;
    bit         zero;
    bit         ovf;
    int         lat;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_pass;
  int   n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    else n_pass++;
  endtask

  task automatic push_exp(input logic [7:0] m, input logic [3:0] s, input logic [4:0] c,
                          input bit z, input bit o, input int l);
    exp_t e;
    e.mant = m; e.shift = s; e.cnt = c; e.zero = z; e.ovf = o; e.lat = l;
    sb.push_back(e);
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the closing element is accepted.
  task automatic drive_frame(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.d[i];
      bus.in_last  = v.last && (i == v.n - 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    push_exp(v.mant, v.shift, v.cnt, v.zero, v.ovf, v.lat);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: result with no expectation queued");
      return;
    end
    e = sb.pop_front();
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("latency",   32'(lat),           32'(e.lat));
    chk("out_mant",  32'(bus.out_mant),  32'(e.mant));
    chk("out_shift", 32'(bus.out_shift), 32'(e.shift));
    chk("out_count", 32'(bus.out_count), 32'(e.cnt));
    chk("out_zero",  32'(bus.out_zero),  32'(e.zero));
    chk("out_ovf",   32'(bus.out_ovf),   32'(e.ovf));
    chk("in_ready_in_out", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_in_ready",  32'(bus.in_ready),  32'd1);
    chk("clr_out_count", 32'(bus.out_count), 32'd0);
    chk("clr_out_mant",  32'(bus.out_mant),  32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_mant"},  32'(bus.out_mant),  32'd0);
    chk({tag, "_out_shift"}, 32'(bus.out_shift), 32'd0);
    chk({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    chk({tag, "_out_zero"},  32'(bus.out_zero),  32'd0);
    chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
  endtask

  task automatic set_vec(input int idx, input int n, input bit last, input logic [7:0] m,
                         input logic [3:0] s, input bit z, input bit o, input int l);
    vecs[idx].n = n; vecs[idx].last = last; vecs[idx].mant = m; vecs[idx].shift = s;
    vecs[idx].cnt = 5'(n); vecs[idx].zero = z; vecs[idx].ovf = o; vecs[idx].lat = l;
    vecs[idx].d = '0;
  endtask

  initial begin
    int   lat;
    vec_t v;
    n_pass  = 0;
    n_total = 0;

    // sum 0x060 -> k=5
    set_vec(0, 3, 1'b1, 8'hC0, 4'd5, 1'b0, 1'b0, 6);
    vecs[0].d[0] = 8'h10; vecs[0].d[1] = 8'h20; vecs[0].d[2] = 8'h30;
    // 16 x 0xFF with no last: forced close
    set_vec(1, 16, 1'b0, 8'hFF, 4'd0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 16; i++) vecs[1].d[i] = 8'hFF;
    set_vec(2, 2, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1);
    // sum 0x101 -> 0x808 after k=3; guard bit is 1
    set_vec(3, 2, 1'b1, RND ? 8'h81 : 8'h80, 4'd3, 1'b0, 1'b0, 4);
    vecs[3].d[0] = 8'hFF; vecs[3].d[1] = 8'h02;
    // sum 0x17D -> 0xBE8
    set_vec(4, 3, 1'b1, RND ? 8'hBF : 8'hBE, 4'd3, 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) vecs[4].d[i] = 8'h7F;
    // last coincides with MAX_LEN: proper close, sum 0x010 -> k=7
    set_vec(5, 16, 1'b1, 8'h80, 4'd7, 1'b0, 1'b0, 8);
    for (int i = 0; i < 16; i++) vecs[5].d[i] = 8'h01;
    // sum 0x1FF -> 0xFF8; rounding must saturate at 0xFF
    set_vec(6, 3, 1'b1, 8'hFF, 4'd3, 1'b0, 1'b0, 4);
    vecs[6].d[0] = 8'hFF; vecs[6].d[1] = 8'hFF; vecs[6].d[2] = 8'h01;
    set_vec(7, 1, 1'b1, 8'h80, 4'd4, 1'b0, 1'b0, 5);
    vecs[7].d[0] = 8'h80;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      chk("start_in_ready", 32'(bus.in_ready), 32'd1);
      drive_frame(vecs[i]);
      wait_out(lat);
      check_out(lat);
      release_out();
    end

    // Hold in OUT with backpressure while in_valid toggles.
    drive_frame(vecs[0]);
    wait_out(lat);
    check_out(lat);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = c[0];
      bus.in_data  = 8'hAA;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_mant",  32'(bus.out_mant),  32'hC0);
      chk("hold_out_count", 32'(bus.out_count), 32'd3);
    end
    // Handshake cycle with a valid element pending: accepted only on the following edge.
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("hs_in_ready",  32'(bus.in_ready),  32'd1);
    push_exp(8'h80, 4'd11, 5'd1, 1'b0, 1'b0, 12);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_out(lat);
    check_out(lat);
    release_out();

    // Asynchronous reset mid-NORM aborts the frame.
    drive_frame(vecs[0]);
    @(posedge clk); #1;
    chk("norm_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_norm");
    sb.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    v = vecs[7];
    v.d[0] = 8'h40; v.shift = 4'd5; v.lat = 6;
    drive_frame(v);
    wait_out(lat);
    check_out(lat);

    // Asynchronous reset while holding a result in OUT.
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_out");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive_frame(vecs[2]);
    wait_out(lat);
    check_out(lat);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
